uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between N_REQ byte producers, such as the terminal echo path and the CPU output/error path. It uses round-robin arbitration. A granted requester can lock the transmitter across a multi-byte sequence (e.g. backspace-space-backspace) so that sequences never interleave. On each requester port it presents the same level-hold TX handshake the UART block exposes, so existing producers connect unchanged.

---
 rtl/forth_uart_pkg.sv | 18 +
 rtl/rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forth_uart_pkg.sv
// Shared definitions for the Forth console UART path: character width,
// arbiter state encoding and the ASCII control characters the producers emit.
package forth_uart_pkg;

    localparam int CHAR_WIDTH = 8;

    localparam logic [CHAR_WIDTH-1:0] BS = 8'h08;
    localparam logic [CHAR_WIDTH-1:0] SP = 8'h20;
    localparam logic [CHAR_WIDTH-1:0] LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO,
        HOLD
    } arbState_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from last+1 (mod N)
// and reports the first requester found as a one-hot grant and an index.
module rr_pick #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index,
    output logic          any
);

    int c;

    // Scan from the farthest candidate back to the nearest so the closest
    // requester after 'last' is the one left standing.
    always_comb begin
        gnt   = '0;
        index = '0;
        any   = 1'b0;
        c     = 0;
        for (int s = N; s >= 1; s--) begin
            c = (int'(last) + s) % N;
            if (req[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                index  = IW'(c);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers with round-robin
// arbitration and an optional per-owner lock for multi-byte sequences.
module uart_tx_arbiter #(
    parameter int N_REQ        = 2,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [N_REQ*8-1:0]   i_data,
    input  logic [N_REQ-1:0]     i_lock,
    output logic [N_REQ-1:0]     o_tx_next,
    output logic [N_REQ-1:0]     o_done,
    output logic [N_REQ-1:0]     o_grant,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_ready,
    input  logic                 i_tx_next
);

    import forth_uart_pkg::*;

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    arbState_e             state_q, state_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [IW-1:0]         gidx_q, gidx_d;
    logic [IW-1:0]         last_q, last_d;
    logic [CHAR_WIDTH-1:0] txData_q, txData_d;
    logic                  txReady_q, txReady_d;
    logic [N_REQ-1:0]      done_q, done_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic [N_REQ-1:0]      pickGnt;
    logic [IW-1:0]         pickIdx;
    logic                  pickAny;
    logic                  timeoutHit;

    rr_pick #(.N(N_REQ)) picker (
        .req   (i_req),
        .last  (last_q),
        .gnt   (pickGnt),
        .index (pickIdx),
        .any   (pickAny)
    );

    // The release cycle itself is the LOCK_TIMEOUT-th idle cycle in HOLD.
    assign timeoutHit = (LOCK_TIMEOUT != 0) && (int'(timer_q) >= LOCK_TIMEOUT - 1);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        txData_d  = txData_q;
        txReady_d = txReady_q;
        done_d    = '0;
        timer_d   = timer_q;
        case (state_q)
            IDLE: begin
                if (pickAny) begin
                    grant_d   = pickGnt;
                    gidx_d    = pickIdx;
                    last_d    = pickIdx;
                    txData_d  = i_data[int'(pickIdx)*CHAR_WIDTH +: CHAR_WIDTH];
                    txReady_d = 1'b1;
                    state_d   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (i_tx_next) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!i_tx_next) begin
                    txReady_d = 1'b0;
                    done_d    = grant_q;
                    timer_d   = '0;
                    if (i_lock[gidx_q]) begin
                        state_d = HOLD;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (i_req[gidx_q]) begin
                    txData_d  = i_data[int'(gidx_q)*CHAR_WIDTH +: CHAR_WIDTH];
                    txReady_d = 1'b1;
                    timer_d   = '0;
                    state_d   = WAIT_HI;
                end else if (!i_lock[gidx_q] || timeoutHit) begin
                    grant_d = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Everything, including the done pulse, freezes while i_en is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= IW'(N_REQ - 1);
            txData_q  <= '0;
            txReady_q <= 1'b0;
            done_q    <= '0;
            timer_q   <= '0;
        end else if (i_en) begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            txData_q  <= txData_d;
            txReady_q <= txReady_d;
            done_q    <= done_d;
            timer_q   <= timer_d;
        end
    end

    assign o_tx_next  = {N_REQ{i_tx_next}} & grant_q;
    assign o_done     = done_q;
    assign o_grant    = grant_q;
    assign o_tx_data  = txData_q;
    assign o_tx_ready = txReady_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized producer
// traffic checked against a transaction-order model of round-robin with locks.
module tb_uart_tx_arbiter;

    import forth_uart_pkg::*;

    localparam int NREQ = 2;
    localparam int TMO  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NREQ-1:0]   reqBus;
    logic [NREQ*8-1:0] dataBus;
    logic [NREQ-1:0]   lockBus;
    logic              txNext;
    logic [NREQ-1:0]   txNextOut;
    logic [NREQ-1:0]   doneOut;
    logic [NREQ-1:0]   grantOut;
    logic [7:0]        txData;
    logic              txReady;

    int checks   = 0;
    int failures = 0;
    int mLast;

    logic [7:0] pData [NREQ][8];
    bit         pLock [NREQ][8];
    int         pHead [NREQ];
    int         pLen [NREQ];
    int         waitCnt [NREQ];
    int         expReq [64];
    logic [7:0] expData [64];
    bit         expLock [64];
    int         expLen;

    uart_tx_arbiter #(.N_REQ(NREQ), .LOCK_TIMEOUT(TMO)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_req      (reqBus),
        .i_data     (dataBus),
        .i_lock     (lockBus),
        .o_tx_next  (txNextOut),
        .o_done     (doneOut),
        .o_grant    (grantOut),
        .o_tx_data  (txData),
        .o_tx_ready (txReady),
        .i_tx_next  (txNext)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish (got running, expected done)");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NREQ-1:0] oneHot(input int k);
        oneHot    = '0;
        oneHot[k] = 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst     = 1'b1;
        en      = 1'b1;
        reqBus  = '0;
        lockBus = '0;
        dataBus = '0;
        txNext  = 1'b0;
        mLast   = NREQ - 1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Plays the UART for one byte: waits for a request, takes it, sends it.
    task automatic serveByte(input string tag, input int k, input logic [7:0] b);
        int t;
        t = 0;
        while (!txReady && t < 50) begin
            tick();
            t++;
        end
        checkOutput({tag, "Ready"}, 32'(txReady), 32'd1);
        checkOutput({tag, "Data"}, 32'(txData), 32'(b));
        checkOutput({tag, "Grant"}, 32'(grantOut), 32'(oneHot(k)));
        txNext = 1'b1;
        repeat (2) tick();
        txNext = 1'b0;
        tick();
        checkOutput({tag, "Done"}, 32'(doneOut), 32'(oneHot(k)));
        checkOutput({tag, "ReadyLow"}, 32'(txReady), 32'd0);
    endtask

    task automatic present(input int k);
        reqBus[k]          = 1'b1;
        dataBus[k*8 +: 8]  = pData[k][pHead[k]];
        lockBus[k]         = pLock[k][pHead[k]];
    endtask

    // One randomized burst: every producer queues 1..5 bytes, some locked.
    task automatic applyStimulus();
        int rem [NREQ];
        int owner, k, j, total, uState, uCnt, uIdx, uOwner, doneCnt, cyc;
        bit found, prevLock;
        total = 0;
        for (int r = 0; r < NREQ; r++) begin
            pLen[r]    = $urandom_range(1, 5);
            pHead[r]   = 0;
            waitCnt[r] = 0;
            rem[r]     = pLen[r];
            total     += pLen[r];
            for (int b = 0; b < pLen[r]; b++) begin
                pData[r][b] = 8'($urandom);
                pLock[r][b] = ($urandom_range(0, 2) == 0);
            end
        end
        owner  = -1;
        expLen = 0;
        while (total > 0) begin
            k = 0;
            if (owner >= 0) begin
                k = owner;
            end else begin
                found = 1'b0;
                for (int s = 1; s <= NREQ; s++) begin
                    if (!found && rem[(mLast + s) % NREQ] > 0) begin
                        k     = (mLast + s) % NREQ;
                        found = 1'b1;
                    end
                end
                mLast = k;
            end
            j               = pLen[k] - rem[k];
            expReq[expLen]  = k;
            expData[expLen] = pData[k][j];
            expLock[expLen] = pLock[k][j];
            expLen++;
            rem[k]--;
            total--;
            owner = (pLock[k][j] && rem[k] > 0) ? k : -1;
        end

        for (int r = 0; r < NREQ; r++) present(r);
        uState = 0; uCnt = 0; uIdx = 0; uOwner = 0; doneCnt = 0; cyc = 0;
        while (!(doneCnt == expLen && grantOut == '0) && cyc < 3000) begin
            tick();
            cyc++;
            checkOutput("txNextFwd", 32'(txNextOut), txNext ? 32'(oneHot(uOwner)) : 32'd0);
            if (uState == 3) begin
                checkOutput("doneOwner", 32'(doneOut), 32'(oneHot(uOwner)));
                checkOutput("readyDrop", 32'(txReady), 32'd0);
                checkOutput("grantAfter", 32'(grantOut), expLock[uIdx-1] ? 32'(oneHot(uOwner)) : 32'd0);
                doneCnt++;
                uState = 0;
            end else begin
                checkOutput("doneQuiet", 32'(doneOut), 32'd0);
            end
            if (uState == 0 && txReady) begin
                uCnt   = $urandom_range(0, 3);
                uState = 1;
            end
            if (uState == 1) begin
                if (uCnt == 0) begin
                    if (uIdx < expLen) begin
                        checkOutput("byteData", 32'(txData), 32'(expData[uIdx]));
                        checkOutput("byteOwner", 32'(grantOut), 32'(oneHot(expReq[uIdx])));
                        uOwner = expReq[uIdx];
                    end else begin
                        checkOutput("extraByte", 32'(uIdx), 32'(expLen - 1));
                    end
                    uIdx++;
                    txNext = 1'b1;
                    uCnt   = $urandom_range(1, 4);
                    uState = 2;
                end else begin
                    uCnt--;
                end
            end else if (uState == 2) begin
                if (uCnt == 0) begin
                    txNext = 1'b0;
                    uState = 3;
                end else begin
                    uCnt--;
                end
            end
            for (int r = 0; r < NREQ; r++) begin
                if (doneOut[r] && pHead[r] < pLen[r]) begin
                    prevLock = pLock[r][pHead[r]];
                    pHead[r]++;
                    if (pHead[r] >= pLen[r]) begin
                        reqBus[r]  = 1'b0;
                        lockBus[r] = 1'b0;
                    end else if (prevLock) begin
                        waitCnt[r] = $urandom_range(0, 2);
                        if (waitCnt[r] == 0) present(r);
                        else reqBus[r] = 1'b0;
                    end else begin
                        present(r);
                    end
                end else if (waitCnt[r] > 0) begin
                    waitCnt[r]--;
                    if (waitCnt[r] == 0) present(r);
                end else if (grantOut[r] && txReady) begin
                    dataBus[r*8 +: 8] = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) reqBus[r] = 1'b0;
                end
            end
        end
        checkOutput("phaseDone", 32'(doneCnt), 32'(expLen));
        checkOutput("phaseBytes", 32'(uIdx), 32'(expLen));
        reqBus  = '0;
        lockBus = '0;
        txNext  = 1'b0;
    endtask

    initial begin
        applyReset();
        checkOutput("rstData", 32'(txData), 32'd0);
        checkOutput("rstReady", 32'(txReady), 32'd0);
        checkOutput("rstGrant", 32'(grantOut), 32'd0);
        checkOutput("rstDone", 32'(doneOut), 32'd0);

        $display("[TB] single byte with late UART strobe");
        reqBus = 2'b01;
        dataBus[7:0] = 8'h41;
        tick();
        checkOutput("singleLatReady", 32'(txReady), 32'd1);
        checkOutput("singleLatData", 32'(txData), 32'h41);
        checkOutput("singleLatGrant", 32'(grantOut), 32'b01);
        dataBus[7:0] = 8'hFF;
        repeat (2) tick();
        txNext = 1'b1;
        #1 checkOutput("singleTxNext", 32'(txNextOut), 32'b01);
        repeat (9) tick();
        checkOutput("singleHeldReady", 32'(txReady), 32'd1);
        checkOutput("singleHeldData", 32'(txData), 32'h41);
        txNext = 1'b0;
        tick();
        checkOutput("singleDone", 32'(doneOut), 32'b01);
        checkOutput("singleReadyLow", 32'(txReady), 32'd0);
        checkOutput("singleGrantFree", 32'(grantOut), 32'd0);
        reqBus = '0;
        tick();
        checkOutput("singleDonePulse", 32'(doneOut), 32'd0);

        $display("[TB] alternation under continuous requests");
        applyReset();
        reqBus  = 2'b11;
        dataBus = {8'h31, 8'h30};
        serveByte("altA", 0, 8'h30);
        serveByte("altB", 1, 8'h31);
        serveByte("altC", 0, 8'h30);
        serveByte("altD", 1, 8'h31);
        reqBus = '0;

        $display("[TB] locked backspace sequence");
        applyReset();
        reqBus  = 2'b11;
        lockBus = 2'b01;
        dataBus = {8'h31, BS};
        serveByte("lockA", 0, BS);
        checkOutput("lockKeep", 32'(grantOut), 32'b01);
        dataBus[7:0] = SP;
        serveByte("lockB", 0, SP);
        dataBus[7:0] = BS;
        lockBus[0] = 1'b0;
        serveByte("lockC", 0, BS);
        reqBus[0] = 1'b0;
        serveByte("lockD", 1, 8'h31);
        reqBus = '0;

        $display("[TB] lock timeout");
        applyReset();
        reqBus  = 2'b11;
        lockBus = 2'b01;
        dataBus = {8'h31, 8'h5A};
        serveByte("tmoA", 0, 8'h5A);
        reqBus[0] = 1'b0;
        repeat (3) begin
            tick();
            checkOutput("tmoHold", 32'(grantOut), 32'b01);
        end
        tick();
        checkOutput("tmoRelease", 32'(grantOut), 32'd0);
        tick();
        checkOutput("tmoRegrant", 32'(grantOut), 32'b10);
        lockBus = '0;
        serveByte("tmoB", 1, 8'h31);
        reqBus = '0;

        $display("[TB] reset during WAIT_LO");
        applyReset();
        reqBus = 2'b01;
        dataBus[7:0] = 8'h55;
        tick();
        txNext = 1'b1;
        tick();
        checkOutput("midReady", 32'(txReady), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncData", 32'(txData), 32'd0);
        checkOutput("asyncReady", 32'(txReady), 32'd0);
        checkOutput("asyncGrant", 32'(grantOut), 32'd0);
        checkOutput("asyncDone", 32'(doneOut), 32'd0);
        txNext = 1'b0;
        reqBus = '0;
        tick();
        rst = 1'b0;
        reqBus  = 2'b11;
        dataBus = {8'h31, 8'h77};
        tick();
        checkOutput("postRstGrant", 32'(grantOut), 32'b01);
        serveByte("postRst", 0, 8'h77);
        reqBus = '0;

        $display("[TB] clock enable freeze");
        applyReset();
        reqBus = 2'b01;
        dataBus[7:0] = 8'h66;
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) txNext = 1'b1;
            dataBus[7:0] = 8'($urandom);
            tick();
            checkOutput("enReady", 32'(txReady), 32'd1);
            checkOutput("enGrant", 32'(grantOut), 32'b01);
        end
        en = 1'b1;
        tick();
        txNext = 1'b0;
        tick();
        checkOutput("enDone", 32'(doneOut), 32'b01);
        checkOutput("enReadyLow", 32'(txReady), 32'd0);
        checkOutput("enData", 32'(txData), 32'h66);
        reqBus = '0;

        $display("[TB] randomized producer traffic");
        applyReset();
        repeat (30) applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
